// File: rtl/mem_arbiter.sv
// Multi-client memory bus arbiter with a programmable access length.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin arbitration; fixed priority otherwise.
module mem_arbiter #(
  parameter int CLIENT_CNT  = 4,
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int WAIT_CYCLES = 1,
  localparam int GNT_W = (CLIENT_CNT > 1) ? $clog2(CLIENT_CNT) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [CLIENT_CNT-1:0]        requests,
  input  logic [CLIENT_CNT*ADDR_W-1:0] addrs,
  input  logic [CLIENT_CNT-1:0]        wes,
  input  logic [CLIENT_CNT*DATA_W-1:0] data_outs,
  input  logic [DATA_W-1:0]            mem_rdata,
  output logic [CLIENT_CNT-1:0]        readies,
  output logic [DATA_W-1:0]            rdata,
  output logic [ADDR_W-1:0]            addr,
  output logic [DATA_W-1:0]            data_out,
  output logic                         we,
  output logic                         busy,
  output logic [GNT_W-1:0]             grant
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  localparam int CNT_W =
    (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(WAIT_CYCLES - 1);

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] cnt;
  logic [GNT_W-1:0] win;
  logic             any_req;
  logic             last_beat;
  logic             take;
  logic             we_q;

  assign any_req   = |requests;
  assign last_beat = (cnt == CNT_LAST);
  assign take      = (state == IDLE) && any_req;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic [GNT_W-1:0] rr_ptr;
  logic [GNT_W-1:0] idx;
  logic             found;

  // Search begins one past the last winner, wrapping at CLIENT_CNT.
  always_comb begin
    win   = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < CLIENT_CNT; i++) begin
      idx = GNT_W'((int'(rr_ptr) + 1 + i) % CLIENT_CNT);
      if (!found && requests[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      rr_ptr <= GNT_W'(CLIENT_CNT - 1);
    else if (take)
      rr_ptr <= win;
  end
`else
  always_comb begin
    win = '0;
    for (int i = 0; i < CLIENT_CNT; i++)
      if (requests[i])
        win = GNT_W'(i);
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (any_req) state_nx = ACCESS;
      ACCESS:  if (last_beat) state_nx = DONE;
      DONE:    if (!requests[grant]) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      addr     <= '0;
      data_out <= '0;
      we_q     <= 1'b0;
      grant    <= '0;
      rdata    <= '0;
    end else begin
      if (take) begin
        addr     <= addrs[int'(win)*ADDR_W +: ADDR_W];
        data_out <= data_outs[int'(win)*DATA_W +: DATA_W];
        we_q     <= wes[win];
        grant    <= win;
        cnt      <= '0;
      end
      if (state == ACCESS) begin
        if (last_beat)
          rdata <= mem_rdata;
        else
          cnt <= cnt + 1'b1;
      end
    end
  end

  // Strobes decode from state so reset drops them without a clock.
  always_comb begin
    we      = 1'b0;
    busy    = 1'b0;
    readies = '0;
    unique case (state)
      ACCESS: begin
        busy = 1'b1;
        we   = we_q;
      end
      DONE: begin
        busy           = 1'b1;
        readies[grant] = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter.
// Covers 4-client/1-wait and 3-client/3-wait builds, both arbitration modes.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;

  logic [3:0]  req_a;
  logic [31:0] addrs_a;
  logic [3:0]  wes_a;
  logic [31:0] douts_a;
  logic [7:0]  mrd_a;
  logic [3:0]  rdy_a;
  logic [7:0]  rdata_a;
  logic [7:0]  addr_a;
  logic [7:0]  dout_a;
  logic        we_a;
  logic        busy_a;
  logic [1:0]  gnt_a;

  logic [2:0]  req_b;
  logic [23:0] addrs_b;
  logic [2:0]  wes_b;
  logic [23:0] douts_b;
  logic [7:0]  mrd_b;
  logic [2:0]  rdy_b;
  logic [7:0]  rdata_b;
  logic [7:0]  addr_b;
  logic [7:0]  dout_b;
  logic        we_b;
  logic        busy_b;
  logic [1:0]  gnt_b;

  int total = 0;
  int bad   = 0;
  int exp_arb[5];
  int n_arb;
  int exp_wrap[4];

  mem_arbiter #(
    .CLIENT_CNT(4), .ADDR_W(8),
    .DATA_W(8), .WAIT_CYCLES(1)
  ) u_a (
    .clk(clk), .rst(rst),
    .requests(req_a), .addrs(addrs_a),
    .wes(wes_a), .data_outs(douts_a),
    .mem_rdata(mrd_a), .readies(rdy_a),
    .rdata(rdata_a), .addr(addr_a),
    .data_out(dout_a), .we(we_a),
    .busy(busy_a), .grant(gnt_a)
  );

  mem_arbiter #(
    .CLIENT_CNT(3), .ADDR_W(8),
    .DATA_W(8), .WAIT_CYCLES(3)
  ) u_b (
    .clk(clk), .rst(rst),
    .requests(req_b), .addrs(addrs_b),
    .wes(wes_b), .data_outs(douts_b),
    .mem_rdata(mrd_b), .readies(rdy_b),
    .rdata(rdata_b), .addr(addr_b),
    .data_out(dout_b), .we(we_b),
    .busy(busy_b), .grant(gnt_b)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
    exp_arb  = '{0, 1, 2, 3, 0};
    n_arb    = 5;
    exp_wrap = '{0, 2, 0, 2};
`else
    exp_arb  = '{3, 2, 1, 0, 0};
    n_arb    = 4;
    exp_wrap = '{2, 2, 2, 2};
`endif
    rst = 1'b1;
    req_a = '0; addrs_a = '0; wes_a = '0;
    douts_a = '0; mrd_a = '0;
    req_b = '0; addrs_b = '0; wes_b = '0;
    douts_b = '0; mrd_b = '0;
    tick;
    chk("rst_rdy", 32'(rdy_a), 32'h0);
    chk("rst_rdata", 32'(rdata_a), 32'h0);
    chk("rst_addr", 32'(addr_a), 32'h0);
    chk("rst_dout", 32'(dout_a), 32'h0);
    chk("rst_we", 32'(we_a), 32'h0);
    chk("rst_busy", 32'(busy_a), 32'h0);
    chk("rst_gnt", 32'(gnt_a), 32'h0);
    chk("rst_busy_b", 32'(busy_b), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    tick;

    // all four clients contend
    req_a   = 4'b1111;
    addrs_a = 32'h33221100;
    for (int k = 0; k < n_arb; k++) begin
      for (int t = 0; t < 12 && rdy_a == 0; t++)
        tick;
      chk("arb_rdy_seen", 32'(rdy_a != 0), 32'h1);
      chk("arb_gnt", 32'(gnt_a), 32'(exp_arb[k]));
      chk("arb_onehot", 32'(rdy_a),
          32'h1 << exp_arb[k]);
      req_a[gnt_a] = 1'b0;
      tick;
      chk("arb_gap_busy", 32'(busy_a), 32'h0);
`ifdef MEM_ARB_ROUND_ROBIN_EN
      req_a[exp_arb[k]] = 1'b1;
`endif
    end
    req_a = '0;
    tick;

    // single write, client 1
    addrs_a = 32'h00003C00;
    douts_a = 32'h0000A500;
    wes_a   = 4'b0010;
    mrd_a   = 8'h77;
    req_a   = 4'b0010;
    tick;
    chk("wr_addr", 32'(addr_a), 32'h3C);
    chk("wr_dout", 32'(dout_a), 32'hA5);
    chk("wr_we", 32'(we_a), 32'h1);
    chk("wr_busy", 32'(busy_a), 32'h1);
    chk("wr_gnt", 32'(gnt_a), 32'h1);
    chk("wr_rdy_early", 32'(rdy_a), 32'h0);
    addrs_a = 32'h0000C300;
    tick;
    chk("wr_rdy", 32'(rdy_a), 32'h2);
    chk("wr_we_off", 32'(we_a), 32'h0);
    chk("wr_rdata", 32'(rdata_a), 32'h77);
    chk("wr_addr_hold", 32'(addr_a), 32'h3C);
    req_a = '0;
    tick;
    chk("wr_rel_rdy", 32'(rdy_a), 32'h0);
    chk("wr_rel_busy", 32'(busy_a), 32'h0);

    // reset lands in the middle of a write
    addrs_a = 32'h00000055;
    douts_a = 32'h00000066;
    wes_a   = 4'b0001;
    req_a   = 4'b0001;
    tick;
    chk("mr_we_pre", 32'(we_a), 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("mr_we", 32'(we_a), 32'h0);
    chk("mr_busy", 32'(busy_a), 32'h0);
    chk("mr_rdy", 32'(rdy_a), 32'h0);
    chk("mr_addr", 32'(addr_a), 32'h0);
    #2 rst = 1'b0;
    tick;
    chk("pr_busy", 32'(busy_a), 32'h1);
    chk("pr_gnt", 32'(gnt_a), 32'h0);
    chk("pr_addr", 32'(addr_a), 32'h55);
    chk("pr_we", 32'(we_a), 32'h1);
    tick;
    chk("pr_rdy", 32'(rdy_a), 32'h1);
    req_a = '0;
    tick;
    chk("pr_rel", 32'(busy_a), 32'h0);

    // client 0 drops mid-access, 3-cycle memory
    req_b = 3'b001;
    tick;
    chk("md_busy", 32'(busy_b), 32'h1);
    chk("md_gnt", 32'(gnt_b), 32'h0);
    tick;
    req_b = '0;
    tick;
    chk("md_rdy_early", 32'(rdy_b), 32'h0);
    tick;
    chk("md_rdy", 32'(rdy_b), 32'h1);
    tick;
    chk("md_rdy_gone", 32'(rdy_b), 32'h0);
    chk("md_busy_gone", 32'(busy_b), 32'h0);

    // read, client 2, data in last access cycle
    addrs_b = 24'h100000;
    wes_b   = 3'b000;
    mrd_b   = 8'h00;
    req_b   = 3'b100;
    tick;
    chk("rd_busy", 32'(busy_b), 32'h1);
    chk("rd_gnt", 32'(gnt_b), 32'h2);
    chk("rd_addr", 32'(addr_b), 32'h10);
    chk("rd_we", 32'(we_b), 32'h0);
    addrs_b = 24'hEE0000;
    tick;
    chk("rd_we_mid", 32'(we_b), 32'h0);
    chk("rd_addr_hold", 32'(addr_b), 32'h10);
    tick;
    chk("rd_rdy_early", 32'(rdy_b), 32'h0);
    mrd_b = 8'h5A;
    tick;
    chk("rd_rdy", 32'(rdy_b), 32'h4);
    chk("rd_rdata", 32'(rdata_b), 32'h5A);
    mrd_b = 8'h11;
    tick;
    chk("rd_rdata_hold", 32'(rdata_b), 32'h5A);
    chk("rd_rdy_hold", 32'(rdy_b), 32'h4);
    req_b = '0;
    tick;
    chk("rd_rel", 32'(busy_b), 32'h0);

    // clients 0 and 2 keep requesting on a 3-client build
    req_b = 3'b101;
    for (int k = 0; k < 4; k++) begin
      for (int t = 0; t < 12 && rdy_b == 0; t++)
        tick;
      chk("wrap_rdy_seen", 32'(rdy_b != 0), 32'h1);
      chk("wrap_gnt", 32'(gnt_b), 32'(exp_wrap[k]));
      chk("wrap_onehot", 32'(rdy_b),
          32'h1 << exp_wrap[k]);
      req_b[gnt_b] = 1'b0;
      tick;
      req_b = 3'b101;
    end
    req_b = '0;
    tick;
    tick;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
